inport_reqctl: RTL

- Input-side request controller for one router input channel; the initiator counterpart of each output's mux controller.
- Buffers incoming flits and decodes the head flit.
- Drives port/req/multab toward all five output mux controllers and collects their grants.
- Streams the packet onto the crossbar, timed to match each output's registered select, then releases the request after the tail.

---
 rtl/inport_reqctl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inport_reqctl.sv
// inport_reqctl: input FIFO, head decode, request/grant FSM; head reaches out_flit 3 cycles after acceptance.
// Backpressure: in_ready low while FIFO full; stalls on partial grant. ARB_TIMEOUT_EN adds multicast RELEASE.
module inport_reqctl #(
  parameter int PORTID  = 0,
  parameter int FLITW   = 34,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  input  logic [FLITW-1:0] in_flit,
  output logic             in_ready,
  output logic [2:0]       port,
  output logic             req,
  output logic             multab,
  input  logic [4:0]       grt_vec,
  input  logic [4:0]       multab_ct_vec,
  output logic [FLITW-1:0] out_flit,
  output logic             out_valid,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [2:0]  PID3    = 3'(PORTID);
  localparam logic [4:0]  MC_MASK = ~(5'b00001 << PORTID);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ARB, XFER, DROP, RELEASE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARB, XFER, DROP} state_t;
`endif

  state_t state, state_nxt;

  logic [FLITW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             push, pop, empty, latch;
  logic [FLITW-1:0] head;
  logic             is_head, is_tail, uturn;
  logic [4:0]       tgt;
  logic             full_grt, tmo_hit;

  assign in_ready = (cnt != FULL);
  assign empty    = (cnt == '0);
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr];
  assign is_head  = head[FLITW-2];
  assign is_tail  = head[FLITW-1];
  assign uturn    = !head[3] && (head[2:0] == PID3);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Every output in the target set must grant in the same cycle before a flit moves.
  always_comb begin
    tgt      = multab ? MC_MASK : (5'b00001 << port);
    full_grt = ((grt_vec & tgt) == tgt);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          ct_hit;

  assign ct_hit  = multab && (state == ARB) && |(multab_ct_vec & tgt);
  assign tmo_hit = ct_hit && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)               tmo_cnt <= '0;
    else if (state != ARB)   tmo_cnt <= '0;
    else if (ct_hit)         tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_ct;
  assign unused_ct = ^{multab_ct_vec, TIMEOUT[0]};
  assign tmo_hit   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (is_head && !uturn) begin
            latch     = 1'b1;
            state_nxt = ARB;
          end else begin
            // Stray non-head flits and u-turn heads are discarded here.
            pop = 1'b1;
            if (is_head && !is_tail) state_nxt = DROP;
          end
        end
      end
      ARB: begin
        if (!empty && full_grt) begin
          pop       = 1'b1;
          state_nxt = is_tail ? IDLE : XFER;
        end else if (tmo_hit) begin
`ifdef ARB_TIMEOUT_EN
          state_nxt = RELEASE;
`endif
        end
      end
      XFER: begin
        if (!empty && full_grt) begin
          pop = 1'b1;
          if (is_tail) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_tail) state_nxt = IDLE;
        end
      end
`ifdef ARB_TIMEOUT_EN
      RELEASE: state_nxt = ARB;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign req  = (state == ARB) || (state == XFER);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      port      <= '0;
      multab    <= 1'b0;
      out_flit  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= pop & req;
      if (pop & req) out_flit <= head;
      if (latch) begin
        port   <= head[2:0];
        multab <= head[3];
      end
    end
  end

endmodule
